// File: rtl/regfile_write_arbiter_pkg.sv
// Shared defaults and types for the register-file write arbiter.
// The write-request struct is sized to the default address/data widths.
package regfile_write_arbiter_pkg;

    localparam int ADDR_W_DEF     = 5;
    localparam int DATA_W_DEF     = 32;
    localparam int DEPTH_DEF      = 4;
    localparam int STARVE_MAX_DEF = 8;

    localparam logic [ADDR_W_DEF-1:0] REG_ZERO = {ADDR_W_DEF{1'b0}};

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback-side bundle: pipeline write, long-latency stream, and the
// register-file write port plus hazard/status outputs.
interface regfile_write_arbiter_if
    import regfile_write_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic                     wb_we;
    logic [ADDR_W-1:0]        wb_addr;
    logic [DATA_W-1:0]        wb_data;
    logic                     lu_valid;
    logic [ADDR_W-1:0]        lu_addr;
    logic [DATA_W-1:0]        lu_data;
    logic                     lu_ready;
    logic                     we3;
    logic [ADDR_W-1:0]        A3;
    logic [DATA_W-1:0]        WD3;
    logic [(1<<ADDR_W)-1:0]   pend_mask;
    logic                     stall_req;
    logic                     waw_err;

    modport master (
        output wb_we, wb_addr, wb_data, lu_valid, lu_addr, lu_data,
        input  lu_ready, we3, A3, WD3, pend_mask, stall_req, waw_err
    );

    modport slave (
        input  wb_we, wb_addr, wb_data, lu_valid, lu_addr, lu_data,
        output lu_ready, we3, A3, WD3, pend_mask, stall_req, waw_err
    );
endinterface

// File: rtl/regfile_write_arbiter_wb_fifo.sv
// Small synchronous circular FIFO for long-latency results, exposing a
// per-entry valid/address view so the owner can decode pending registers.
module wb_fifo
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_push,
    input  logic [ADDR_W-1:0]             i_addr,
    input  logic [DATA_W-1:0]             i_data,
    input  logic                          i_pop,
    output logic [ADDR_W-1:0]             o_head_addr,
    output logic [DATA_W-1:0]             o_head_data,
    output logic [$clog2(DEPTH):0]        o_count,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [DEPTH-1:0]              o_ent_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0]  o_ent_addr
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    assign o_full      = (r_count == CNT_W'(DEPTH));
    assign o_empty     = (r_count == {CNT_W{1'b0}});
    assign w_push      = i_push && !o_full;
    assign w_pop       = i_pop && !o_empty;
    assign o_count     = r_count;
    assign o_head_addr = r_addr[r_rd_ptr];
    assign o_head_data = r_data[r_rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are qualified by the occupancy view, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr] <= i_addr;
            r_data[r_wr_ptr] <= i_data;
        end
    end

    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        o_ent_valid = {DEPTH{1'b0}};
        o_ent_addr  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_ent_valid[i] = ({1'b0, PTR_W'(i) - r_rd_ptr} < r_count);
            o_ent_addr[i]  = r_addr[i];
        end
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: the non-stallable pipeline writeback
// always wins; queued long-latency results drain in the idle slots.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    regfile_write_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int AGE_W = $clog2(STARVE_MAX + 1);
    localparam int NREG  = 1 << ADDR_W;

    logic                         w_pw;
    logic                         w_store;
    logic                         w_pop;
    logic                         w_waiting;
    logic                         w_full;
    logic                         w_empty;
    logic [CNT_W-1:0]             w_count;
    logic [ADDR_W-1:0]            w_head_addr;
    logic [DATA_W-1:0]            w_head_data;
    logic [DEPTH-1:0]             w_ent_valid;
    logic [DEPTH-1:0][ADDR_W-1:0] w_ent_addr;
    logic [NREG-1:0]              w_pend_mask;

    logic                         r_we3;
    logic [ADDR_W-1:0]            r_a3;
    logic [DATA_W-1:0]            r_wd3;
    logic [AGE_W-1:0]             r_age;
    logic                         r_stall_req;
    logic                         r_waw_err;

    // Zero-destination long-latency results complete the handshake but are dropped.
    assign w_pw      = bus.wb_we && (bus.wb_addr != ADDR_W'(REG_ZERO));
    assign w_store   = bus.lu_valid && !w_full && (bus.lu_addr != ADDR_W'(REG_ZERO));
    assign w_pop     = !w_pw && !w_empty;
    assign w_waiting = (w_count != {CNT_W{1'b0}}) && !w_pop;

    wb_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_store),
        .i_addr      (bus.lu_addr),
        .i_data      (bus.lu_data),
        .i_pop       (w_pop),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_ent_valid (w_ent_valid),
        .o_ent_addr  (w_ent_addr)
    );

    // Pending-write mask: OR of the destinations of every live FIFO entry.
    always_comb begin
        w_pend_mask = {NREG{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            w_pend_mask[w_ent_addr[i]] = w_pend_mask[w_ent_addr[i]] | w_ent_valid[i];
        end
    end

    // Write-port register; idle cycles drive zero address/data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we3 <= 1'b0;
            r_a3  <= {ADDR_W{1'b0}};
            r_wd3 <= {DATA_W{1'b0}};
        end else if (w_pw) begin
            r_we3 <= 1'b1;
            r_a3  <= bus.wb_addr;
            r_wd3 <= bus.wb_data;
        end else if (w_pop) begin
            r_we3 <= 1'b1;
            r_a3  <= w_head_addr;
            r_wd3 <= w_head_data;
        end else begin
            r_we3 <= 1'b0;
            r_a3  <= {ADDR_W{1'b0}};
            r_wd3 <= {DATA_W{1'b0}};
        end
    end

    // Head-of-queue starvation tracking; age saturates at STARVE_MAX.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_age       <= {AGE_W{1'b0}};
            r_stall_req <= 1'b0;
        end else if (!w_waiting) begin
            r_age       <= {AGE_W{1'b0}};
            r_stall_req <= 1'b0;
        end else begin
            if (r_age < AGE_W'(STARVE_MAX)) begin
                r_age <= r_age + AGE_W'(1);
            end
            r_stall_req <= r_stall_req || (r_age >= AGE_W'(STARVE_MAX - 1));
        end
    end

    // Sticky write-after-write flag against queued entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_waw_err <= 1'b0;
        end else if (w_pw && w_pend_mask[bus.wb_addr]) begin
            r_waw_err <= 1'b1;
        end else begin
            r_waw_err <= r_waw_err;
        end
    end

    assign bus.lu_ready  = !w_full;
    assign bus.we3       = r_we3;
    assign bus.A3        = r_a3;
    assign bus.WD3       = r_wd3;
    assign bus.pend_mask = w_pend_mask;
    assign bus.stall_req = r_stall_req;
    assign bus.waw_err   = r_waw_err;
endmodule
